// File: rtl/ws2812b_frame_sequencer_pkg.sv
// Shared timing defaults, FSM encodings and helpers for the WS2812B frame sequencer.
package ws2812b_frame_sequencer_pkg;

    localparam int DEF_LED_COUNT      = 24;
    localparam int DEF_BIT_CYCLES     = 15;
    localparam int DEF_T0H_CYCLES     = 4;
    localparam int DEF_T1H_CYCLES     = 9;
    localparam int DEF_LATCH_CYCLES   = 1200;
    localparam int DEF_REFRESH_CYCLES = 0;

    localparam int PIX_W = 24;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;

    // A one-LED chain still needs a 1-bit address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ws2812b_frame_sequencer_if.sv
// Pixel RAM read port: the sequencer masters address/strobe, the RAM answers one clock later.
interface ws2812b_frame_sequencer_if #(
    parameter int AW = 5
);
    import ws2812b_frame_sequencer_pkg::*;

    logic [AW-1:0]    pix_addr;
    logic             pix_rd;
    logic [PIX_W-1:0] pix_data;

    modport master (output pix_addr, output pix_rd, input pix_data);
    modport slave  (input pix_addr, input pix_rd, output pix_data);

endinterface

// File: rtl/ws2812b_frame_sequencer_bit_encoder.sv
// Per-bit waveform generator: a phase counter that shapes one WS2812B bit period.
module ws2812b_frame_sequencer_bit_encoder
    import ws2812b_frame_sequencer_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic bit_i,
    output logic dout_o,
    output logic bit_first_o,
    output logic bit_last_o
);

    logic [3:0] phase_q, phase_d;

    // Phase restarts at 0 whenever the encoder is idle or a bit period completes.
    always_comb begin
        bit_last_o  = en_i && (phase_q == 4'(BIT_CYCLES - 1));
        bit_first_o = en_i && (phase_q == 4'd0);
        dout_o      = en_i && (phase_q < (bit_i ? 4'(T1H_CYCLES) : 4'(T0H_CYCLES)));
        phase_d     = (en_i && !bit_last_o) ? phase_q + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// WS2812B frame controller: fetches GRB words from pixel RAM and streams them
// gap-free onto the LED data pin, then holds the latch gap.
module ws2812b_frame_sequencer
    import ws2812b_frame_sequencer_pkg::*;
#(
    parameter int LED_COUNT      = DEF_LED_COUNT,
    parameter int BIT_CYCLES     = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES     = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES     = DEF_T1H_CYCLES,
    parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    ws2812b_frame_sequencer_if.master  pix,
    output logic                       dout_o,
    output logic                       busy_o,
    output logic                       frame_done_o
);

    localparam int AW = addr_width(LED_COUNT);
    localparam int LW = $clog2(LATCH_CYCLES + 1);

    if (LED_COUNT < 1) begin : g_bad_led_count
        $error("ws2812b_frame_sequencer: LED_COUNT must be at least 1");
    end
    if (!((T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES) && (BIT_CYCLES <= 16))) begin : g_bad_bit_timing
        $error("ws2812b_frame_sequencer: need T0H < T1H < BIT_CYCLES <= 16");
    end
    if (LATCH_CYCLES < 1) begin : g_bad_latch
        $error("ws2812b_frame_sequencer: LATCH_CYCLES must be at least 1");
    end

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    pix_idx_q, pix_idx_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [PIX_W-1:0] shreg_q, shreg_d;
    logic [PIX_W-1:0] hold_q, hold_d;
    logic [LW-1:0]    latch_q, latch_d;
    logic             pend_q, pend_d;
    logic             rd_q;

    logic             send_en, bit_first, bit_last, last_pix;
    logic             prefetch, latch_last, refresh_tick, req, busy;
    logic [PIX_W-1:0] next_word;

    if (REFRESH_CYCLES > 0) begin : g_refresh
        localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
        logic [RW-1:0] refresh_q;

        assign refresh_tick = (refresh_q == RW'(REFRESH_CYCLES - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                refresh_q <= '0;
            end else if (refresh_tick) begin
                refresh_q <= '0;
            end else begin
                refresh_q <= refresh_q + RW'(1);
            end
        end
    end else begin : g_no_refresh
        assign refresh_tick = 1'b0;
    end

    assign req        = start_i || refresh_tick;
    assign busy       = (state_q != ST_IDLE);
    assign send_en    = (state_q == ST_SEND);
    assign last_pix   = (pix_idx_q == AW'(LED_COUNT - 1));
    assign prefetch   = send_en && bit_first && (bit_idx_q == 5'd0) && !last_pix;
    assign latch_last = (state_q == ST_LATCH) && (latch_q == LW'(LATCH_CYCLES - 1));
    // A read issued on bit 0's first clock may still be in flight on its last clock.
    assign next_word  = rd_q ? pix.pix_data : hold_q;

    ws2812b_frame_sequencer_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_bit_encoder (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (send_en),
        .bit_i       (shreg_q[PIX_W-1]),
        .dout_o      (dout_o),
        .bit_first_o (bit_first),
        .bit_last_o  (bit_last)
    );

    assign pix.pix_rd   = (state_q == ST_FETCH) || prefetch;
    assign pix.pix_addr = prefetch ? pix_idx_q + AW'(1) : '0;
    assign busy_o       = busy;
    assign frame_done_o = latch_last;

    // Requests arriving mid-frame collapse into a single pending frame.
    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        hold_d    = hold_q;
        latch_d   = latch_q;
        pend_d    = pend_q;

        if (req && busy) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pix_idx_d = '0;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_d   = pix.pix_data;
                bit_idx_d = 5'd23;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (rd_q) begin
                    hold_d = pix.pix_data;
                end
                if (bit_last) begin
                    if (bit_idx_q != 5'd0) begin
                        shreg_d   = {shreg_q[PIX_W-2:0], 1'b0};
                        bit_idx_d = bit_idx_q - 5'd1;
                    end else if (!last_pix) begin
                        shreg_d   = next_word;
                        bit_idx_d = 5'd23;
                        pix_idx_d = pix_idx_q + AW'(1);
                    end else begin
                        latch_d = '0;
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                latch_d = latch_q + LW'(1);
                if (latch_last) begin
                    state_d = (pend_q || req) ? ST_FETCH : ST_IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pix_idx_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            hold_q    <= '0;
            latch_q   <= '0;
            pend_q    <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_idx_q <= pix_idx_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            latch_q   <= latch_d;
            pend_q    <= pend_d;
            rd_q      <= prefetch;
        end
    end

endmodule
